// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative 33-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Magnitudes are iterated unsigned for WIDTH cycles; signs are applied in the FIX cycle.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 div_q, div_d, neg_q, neg_d, sa_q, sa_d, bz_q, bz_d, done_q, done_d;
    logic [WIDTH-1:0]     m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, prod;
    logic                 a_neg, b_neg, fits;
    logic [WIDTH-1:0]     a_mag, b_mag, trial, quo, rem;
    logic [WIDTH:0]       add_sum;
    always_comb begin
        a_neg   = ~op[0] & A[WIDTH-1];
        b_neg   = ~op[0] & B[WIDTH-1];
        a_mag   = a_neg ? -A : A;
        b_mag   = b_neg ? -B : B;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
        // Shifted partial remainder is WIDTH+1 bits; its top bit alone guarantees the subtract fits.
        fits    = acc_q[2*WIDTH-1] | (acc_q[2*WIDTH-2:WIDTH-1] >= m_q);
        trial   = acc_q[2*WIDTH-2:WIDTH-1] - m_q;
        prod    = neg_q ? -acc_q : acc_q;
        quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem     = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        bz_d    = bz_q;
        m_d     = m_q;
        a_d     = a_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                hi_d = mthi ? wdata : hi_q;
                lo_d = mtlo ? wdata : lo_q;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = op[1];
                    neg_d   = a_neg ^ b_neg;
                    sa_d    = a_neg;
                    bz_d    = B == '0;
                    m_d     = b_mag;
                    a_d     = A;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                end
            end
            RUN: begin
                acc_d   = !div_q ? {add_sum, acc_q[WIDTH-1:1]} :
                          fits   ? {trial, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] : bz_q ? a_q : rem;
                lo_d    = !div_q ? prod[WIDTH-1:0] : bz_q ? {WIDTH{1'b1}} : quo;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            bz_q    <= 1'b0;
            m_q     <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            bz_q    <= bz_d;
            m_q     <= m_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit owning the architectural HI/LO register pair. It sits beside the ALU in the execute stage and executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle latency. It uses a start/busy/done handshake and serves MFHI/MFLO reads and MTHI/MTLO writes. The pipeline control stalls on `busy`.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request an operation; sampled only when idle.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  in  WIDTH  multiplicand or dividend (rs).
- B  in  WIDTH  multiplier or divisor (rt).
- mthi  in  1  write `wdata` to HI.
- mtlo  in  1  write `wdata` to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO receive a result.
- hi  out  WIDTH  current HI register (MFHI path).
- lo  out  WIDTH  current LO register (MFLO path).

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE:**
  - `start=1` latches `op` and the operand magnitudes. For signed ops a negative operand is two's-complement negated; for unsigned ops operands are taken as-is.
  - Also latches the sign flags, clears the iteration counter and moves to RUN.
- **RUN, one iteration per cycle for 32 cycles:**
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - Counter 0..31; when the counter reaches 31 the state moves to FIX.
- **FIX, one cycle:**
  - Applies sign correction and writes HI/LO, pulses `done`, returns to IDLE.
  - Multiply: {HI,LO} = 64-bit product, negated if the operand signs differ (signed op only).
  - Divide: LO = quotient, negated if signs differ. HI = remainder, carrying the sign of the dividend (signed op only).
- **Divide by zero (B==0, DIV or DIVU):** no exception. LO = 32'hFFFFFFFF, HI = A unmodified. Full latency still applies.
- **Signed overflow (-2^31 / -1):** LO = 32'h80000000, HI = 0.
- **MTHI/MTLO:**
  - Accepted only while `busy=0`; written at that edge. Dropped silently while busy.
  - In IDLE, `mthi`/`mtlo` coincident with `start`: the write occurs and the operation is also accepted. The result overwrites HI/LO at FIX.
- **`start` while busy:** ignored; no queueing.
- **Outputs:** `hi`/`lo` are always the registered values. Intermediate RUN state never appears on `hi`/`lo`.

## Timing
- **Reset** (rst_n=0 at an edge): state IDLE, counter 0, internal accumulators 0, `hi`=0, `lo`=0, `busy`=0, `done`=0.
- **Reset mid-operation:** aborts. No `done`, HI/LO cleared to 0.
- **Operation timeline** (start sampled at edge E0):
  - `busy`=1 from after E0 through before E33 (33 cycles).
  - At E33, HI/LO are updated, `done`=1 for exactly one cycle and `busy`=0.
- **Back-to-back:** `start` may be reasserted in the same cycle `done` is high. It is sampled at E34 and the next result appears at E67. Issue interval is 34 cycles.
- **`busy` timing:** `busy` is registered and rises the cycle after `start`. The stall logic treats `start` itself as busy for that first cycle.
- **`hi`/`lo` timing:** change only at an accepted MTHI/MTLO edge, at FIX, or at reset.
- **Counter wrap:** none; the counter is reset on every accepted start.

## Test plan
- **MULT signed:** A=0xFFFFFFFD (-3), B=7 -> at E33 done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles.
- **MULTU then DIV back-to-back:**
  - MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - Then start in the done cycle: DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at E67.
- **DIVU by zero:** A=0x64, B=0 -> LO=0xFFFFFFFF, HI=0x64 after 33 cycles. Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- **Handshake abuse:**
  - During RUN of MULTU 5*6, pulse start with other operands and pulse mthi wdata=0xDEADBEEF -> both ignored; result HI=0, LO=0x1E.
  - Afterwards, in idle, mtlo wdata=0x12345678 -> LO=0x12345678 next cycle; HI is unchanged.
- **Reset mid-op:** start DIVU 1000/3, drop rst_n for one edge at cycle 10 -> busy=0, hi=lo=0, no done pulse ever. A fresh DIVU 1000/3 -> LO=0x14D, HI=1.
